imem_port_arbiter: RTL and testbench

Shares one byte-wide, single-ported instruction ROM between two read requesters: instruction fetch (IF) and a data-side load port (LS).
- Grants one request at a time, round-robin.
- Issues four sequential byte reads and assembles a big-endian 32-bit word.
- Returns the word to the owner with a one-cycle valid pulse.
- Sits between the fetch stage / load unit and a synchronous-read ROM macro.

---
 rtl/imem_arb_pkg.sv | 45 ++++
 rtl/rr_arbiter2.sv | 61 ++++++
 rtl/imem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_arb_pkg
// Purpose  : Shared types, constants and a byte-insert helper for the
//            instruction-ROM port arbiter.
// Contents : state_e  - transaction FSM states
//            owner_e  - which requester owns the current transaction
//            NumBytes - bytes fetched per word
//            put_byte - big-endian byte insertion into a 32-bit word
// Revision : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int NumBytes = 4;
  localparam int IdxBits  = $clog2(NumBytes);

  // Byte at offset 0 lands in bits 31:24 (big-endian assembly).
  function automatic logic [31:0] put_byte(input logic [31:0]        word,
                                           input logic [IdxBits-1:0] idx,
                                           input logic [7:0]         b);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[31:24] = b;
      2'd1:    res[23:16] = b;
      2'd2:    res[15:8]  = b;
      default: res[7:0]   = b;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-request round-robin picker. Purely combinational apart from
//            the last_owner register, which moves to the winner whenever the
//            caller accepts a grant.
// Ports    : clk_i, rst_ni        - clock, async active-low reset
//            req_if_i, req_ls_i   - pending requests
//            en_i                 - grants may be issued this cycle
//            accept_i             - a grant was taken; remember its owner
//            gnt_if_o, gnt_ls_o   - one-hot grant (0 when en_i is low)
//            winner_o             - requester that would win this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import imem_arb_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   req_if_i,
  input  logic   req_ls_i,
  input  logic   en_i,
  input  logic   accept_i,
  output logic   gnt_if_o,
  output logic   gnt_ls_o,
  output owner_e winner_o
);

  owner_e last_owner_q, last_owner_d;

  always_comb begin
    winner_o = OWN_IF;
    if (req_if_i && req_ls_i) begin
      // On a tie the side that did not go last wins.
      winner_o = (last_owner_q == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (req_ls_i) begin
      winner_o = OWN_LS;
    end
  end

  assign gnt_if_o = en_i && req_if_i && (winner_o == OWN_IF);
  assign gnt_ls_o = en_i && req_ls_i && (winner_o == OWN_LS);

  always_comb begin
    last_owner_d = last_owner_q;
    if (accept_i) begin
      last_owner_d = winner_o;
    end
  end

  // LS as the reset owner makes IF win the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_owner_q <= OWN_LS;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares a byte-wide synchronous-read instruction ROM between the
//            instruction-fetch (IF) and load (LS) requesters. A granted
//            request is served by four sequential byte reads assembled into a
//            big-endian word, returned with a one-cycle rvalid pulse.
//            Timeline: grant T, ROM reads T+1..T+4, rvalid T+6.
// Ports    : clk_i, rst_ni                     - clock, async active-low reset
//            if_req_i/if_addr_i/if_gnt_o       - IF request handshake
//            if_rvalid_o/if_rdata_o            - IF response
//            ls_*                              - same set for LS
//            mem_en_o/mem_addr_o/mem_rdata_i   - ROM interface (1-cycle read)
//            if_err_o/ls_err_o                 - misalignment error (macro only)
// Config   : IMEM_MISALIGN_ERR_EN - when defined, a request whose address is
//            not word-aligned skips the ROM and responds with rdata=0 and an
//            err pulse alongside rvalid.
// Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int RegBits  = 32,
  parameter int AddrBits = 19
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [RegBits-1:0]  if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [RegBits-1:0]  if_rdata_o,
  input  logic                ls_req_i,
  input  logic [RegBits-1:0]  ls_addr_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [RegBits-1:0]  ls_rdata_o,
`ifdef IMEM_MISALIGN_ERR_EN
  output logic                if_err_o,
  output logic                ls_err_o,
`endif
  output logic                mem_en_o,
  output logic [AddrBits-1:0] mem_addr_o,
  input  logic [7:0]          mem_rdata_i
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [AddrBits-1:0]   base_q,  base_d;
  logic [IdxBits-1:0]    k_q,     k_d;
  logic [IdxBits-1:0]    idx_q,   idx_d;
  logic                  pend_q,  pend_d;
  logic [31:0]           buf_q,   buf_d;
  logic [31:0]           word_q,  word_d;
`ifdef IMEM_MISALIGN_ERR_EN
  logic                  err_q,   err_d;
`endif

  logic                  w_arb_en;
  logic                  w_gnt_if;
  logic                  w_gnt_ls;
  logic                  w_start;
  owner_e                w_winner;
  logic [AddrBits-1:0]   w_sel_addr;
  logic                  w_resp;
  logic                  w_unused_addr_bits;

  // Upper request address bits are deliberately ignored.
  assign w_unused_addr_bits = ^{if_addr_i[RegBits-1:AddrBits],
                                ls_addr_i[RegBits-1:AddrBits]};

  // Gating with rst_ni keeps grants low for the whole reset pulse, not just
  // after the first edge.
  assign w_arb_en = rst_ni && (state_q == IDLE);

  rr_arbiter2 u_rr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_if_i (if_req_i),
    .req_ls_i (ls_req_i),
    .en_i     (w_arb_en),
    .accept_i (w_start),
    .gnt_if_o (w_gnt_if),
    .gnt_ls_o (w_gnt_ls),
    .winner_o (w_winner)
  );

  assign w_start    = w_gnt_if || w_gnt_ls;
  assign w_sel_addr = (w_winner == OWN_LS) ? ls_addr_i[AddrBits-1:0]
                                           : if_addr_i[AddrBits-1:0];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    k_d     = k_q;
    idx_d   = idx_q;
    pend_d  = 1'b0;
    buf_d   = buf_q;
    word_d  = word_q;
`ifdef IMEM_MISALIGN_ERR_EN
    err_d   = err_q;
`endif

    // A read issued last cycle returns its byte now, whatever the state.
    if (pend_q) begin
      buf_d = put_byte(buf_q, idx_q, mem_rdata_i);
    end

    case (state_q)
      IDLE: begin
        if (w_start) begin
          owner_d = w_winner;
          base_d  = w_sel_addr;
          k_d     = '0;
          state_d = ISSUE;
`ifdef IMEM_MISALIGN_ERR_EN
          err_d   = (w_sel_addr[1:0] != 2'b00);
          if (w_sel_addr[1:0] != 2'b00) begin
            word_d  = '0;
            state_d = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        pend_d = 1'b1;
        idx_d  = k_q;
        k_d    = k_q + 1'b1;
        if (k_q == IdxBits'(NumBytes - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // buf_d already holds the final byte arriving this cycle.
        word_d  = buf_d;
        state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      base_q  <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      word_q  <= '0;
`ifdef IMEM_MISALIGN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
`ifdef IMEM_MISALIGN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign if_gnt_o    = w_gnt_if;
  assign ls_gnt_o    = w_gnt_ls;

  assign mem_en_o    = (state_q == ISSUE);
  // Natural AddrBits-wide addition gives the modulo-2**AddrBits wrap.
  assign mem_addr_o  = (state_q == ISSUE) ? (base_q + AddrBits'(k_q)) : '0;

  assign w_resp      = (state_q == RESP);
  assign if_rvalid_o = w_resp && (owner_q == OWN_IF);
  assign ls_rvalid_o = w_resp && (owner_q == OWN_LS);
  assign if_rdata_o  = RegBits'(word_q);
  assign ls_rdata_o  = RegBits'(word_q);

`ifdef IMEM_MISALIGN_ERR_EN
  assign if_err_o    = if_rvalid_o && err_q;
  assign ls_err_o    = ls_rvalid_o && err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_port_arbiter
// Purpose  : Self-checking bench for imem_port_arbiter with a behavioural
//            synchronous-read ROM. Single transactions come from a vector
//            table; arbitration, reset abort and misaligned reads use
//            hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

  localparam int RegBits  = 32;
  localparam int AddrBits = 19;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic                if_req_i;
  logic [RegBits-1:0]  if_addr_i;
  logic                if_gnt_o;
  logic                if_rvalid_o;
  logic [RegBits-1:0]  if_rdata_o;
  logic                ls_req_i;
  logic [RegBits-1:0]  ls_addr_i;
  logic                ls_gnt_o;
  logic                ls_rvalid_o;
  logic [RegBits-1:0]  ls_rdata_o;
`ifdef IMEM_MISALIGN_ERR_EN
  logic                if_err_o;
  logic                ls_err_o;
`endif
  logic                mem_en_o;
  logic [AddrBits-1:0] mem_addr_o;
  logic [7:0]          mem_rdata_i = 8'h00;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom [int];

  always #5 clk = ~clk;

  // Synchronous-read ROM: data one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= rom.exists(int'(mem_addr_o)) ? rom[int'(mem_addr_o)] : 8'h00;
    end
  end

  imem_port_arbiter #(.RegBits(RegBits), .AddrBits(AddrBits)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .ls_req_i    (ls_req_i),
    .ls_addr_i   (ls_addr_i),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
`ifdef IMEM_MISALIGN_ERR_EN
    .if_err_o    (if_err_o),
    .ls_err_o    (ls_err_o),
`endif
    .mem_en_o    (mem_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_gnt"},    32'(if_gnt_o),    32'd0);
    chk({tag, " ls_gnt"},    32'(ls_gnt_o),    32'd0);
    chk({tag, " mem_en"},    32'(mem_en_o),    32'd0);
    chk({tag, " mem_addr"},  32'(mem_addr_o),  32'd0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid_o), 32'd0);
    chk({tag, " ls_rvalid"}, 32'(ls_rvalid_o), 32'd0);
    chk({tag, " if_rdata"},  if_rdata_o,       32'd0);
    chk({tag, " ls_rdata"},  ls_rdata_o,       32'd0);
  endtask

  // Raise one request at a negedge and expect an immediate grant.
  task automatic start(input bit is_ls, input logic [31:0] addr);
    @(negedge clk);
    if (is_ls) begin ls_req_i = 1'b1; ls_addr_i = addr; end
    else       begin if_req_i = 1'b1; if_addr_i = addr; end
    #1;
    chk("grant if", 32'(if_gnt_o), 32'(!is_ls));
    chk("grant ls", 32'(ls_gnt_o), 32'(is_ls));
  endtask

  // Follow a granted transaction from T+1 to T+6; the requester drops req at
  // T+1 and optionally scrambles its address.
  task automatic follow(input bit is_ls, input logic [31:0] addr,
                        input logic [31:0] word, input bit scramble);
    logic [AddrBits-1:0] base;
    logic [AddrBits-1:0] exp_addr;
    bit mis;
    bit resp;
    base = addr[AddrBits-1:0];
    mis  = 1'b0;
`ifdef IMEM_MISALIGN_ERR_EN
    mis  = (addr[1:0] != 2'b00);
`endif
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (is_ls) begin ls_req_i = 1'b0; if (scramble) ls_addr_i = 32'h40; end
        else       begin if_req_i = 1'b0; if (scramble) if_addr_i = 32'h40; end
      end
      #1;
      resp     = mis ? (c == 1) : (c == 6);
      exp_addr = base + AddrBits'(c - 1);
      chk("mem_en", 32'(mem_en_o), 32'(!mis && c <= 4));
      if (!mis && c <= 4) chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
      chk("busy if_gnt", 32'(if_gnt_o), 32'd0);
      chk("busy ls_gnt", 32'(ls_gnt_o), 32'd0);
      chk("if_rvalid", 32'(if_rvalid_o), 32'(resp && !is_ls));
      chk("ls_rvalid", 32'(ls_rvalid_o), 32'(resp && is_ls));
      if (resp) begin
        chk("if_rdata", if_rdata_o, mis ? 32'd0 : word);
        chk("ls_rdata", ls_rdata_o, mis ? 32'd0 : word);
`ifdef IMEM_MISALIGN_ERR_EN
        chk("if_err", 32'(if_err_o), 32'(mis && !is_ls));
        chk("ls_err", 32'(ls_err_o), 32'(mis && is_ls));
`endif
      end
    end
  endtask

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    logic [31:0] word;
    bit          scramble;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // ROM contents
    rom[32'h100] = 8'h13; rom[32'h101] = 8'h05; rom[32'h102] = 8'h10; rom[32'h103] = 8'h00;
    rom[32'h40]  = 8'hDE; rom[32'h41]  = 8'hAD; rom[32'h42]  = 8'hBE; rom[32'h43]  = 8'hEF;
    rom[32'h7FFFE] = 8'h11; rom[32'h7FFFF] = 8'h22;
    rom[32'h0] = 8'h33; rom[32'h1] = 8'h44; rom[32'h2] = 8'h55; rom[32'h3] = 8'h66;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h1305_1000, 1'b0};
    vecs[1] = '{1'b1, 32'h0007_FFFE, 32'h1122_3344, 1'b0};  // address wrap
    vecs[2] = '{1'b0, 32'h0008_0100, 32'h1305_1000, 1'b0};  // upper bits ignored
    vecs[3] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h3344_5566, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h1305_1000, 1'b1};  // req/addr change after grant
    vecs[6] = '{1'b1, 32'h0000_0002, 32'h5566_0000, 1'b0};  // misaligned

    // Reset: outputs zero and grants suppressed even with requests present.
    rst_ni    = 1'b0;
    if_req_i  = 1'b1; if_addr_i = 32'h100;
    ls_req_i  = 1'b1; ls_addr_i = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    if_req_i = 1'b0; ls_req_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    // Both requesting from reset: IF, LS, IF, LS every 7 cycles.
    @(negedge clk);
    if_addr_i = 32'h0; ls_addr_i = 32'h40;
    if_req_i = 1'b1; ls_req_i = 1'b1;
    for (int c = 0; c < 28; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("rr if_gnt", 32'(if_gnt_o), 32'(c % 14 == 0));
      chk("rr ls_gnt", 32'(ls_gnt_o), 32'(c % 14 == 7));
      chk("rr if_rvalid", 32'(if_rvalid_o), 32'(c % 14 == 6));
      chk("rr ls_rvalid", 32'(ls_rvalid_o), 32'(c % 14 == 13));
      if (c % 14 == 6)  chk("rr if_rdata", if_rdata_o, 32'h3344_5566);
      if (c % 14 == 13) chk("rr ls_rdata", ls_rdata_o, 32'hDEAD_BEEF);
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;

    // Vector table: single transactions.
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].is_ls, vecs[i].addr);
      follow(vecs[i].is_ls, vecs[i].addr, vecs[i].word, vecs[i].scramble);
    end

    // Reset during ISSUE k=2, requests held through reset.
    start(1'b0, 32'h100);
    repeat (3) @(negedge clk);
    #1;
    chk("abort mem_addr k2", 32'(mem_addr_o), 32'h102);
    ls_req_i = 1'b1; ls_addr_i = 32'h40;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("post-reset if_gnt", 32'(if_gnt_o), 32'd1);
    chk("post-reset ls_gnt", 32'(ls_gnt_o), 32'd0);
    chk("post-reset if_rvalid", 32'(if_rvalid_o), 32'd0);
    follow(1'b0, 32'h100, 32'h1305_1000, 1'b0);
    @(negedge clk);
    #1;
    chk("post-reset ls turn", 32'(ls_gnt_o), 32'd1);
    follow(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);

    // Misaligned LS read at 0x101.
    rom[32'h101] = 8'hAA; rom[32'h102] = 8'hBB; rom[32'h103] = 8'hCC; rom[32'h104] = 8'hDD;
    start(1'b1, 32'h101);
    follow(1'b1, 32'h101, 32'hAABB_CCDD, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
